// File: rtl/gzip_job_sequencer.sv
// Job sequencer between the register/stream front end and the Deflate core.
// Define GZIP_SEQ_TIMEOUT_EN to build the FEED/DRAIN progress watchdog.
module gzip_job_sequencer #(
  parameter int RST_CYCLES     = 4,
  parameter int WORDS_WIDTH    = 24,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   core_clock,
  input  logic                   bus_reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [WORDS_WIDTH-1:0] job_words,
  input  logic [1:0]             job_btype,
  input  logic                   job_rev_endian,
  input  logic [31:0]            s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic                   core_wr_en,
  output logic [31:0]            core_wr_data,
  input  logic                   core_full,
  output logic                   gzip_rst_n,
  output logic [1:0]             gzip_btype,
  output logic                   gzip_rev_endianness,
  input  logic                   core_done,
  input  logic                   core_btype_error,
  input  logic                   core_block_size_error,
  input  logic [31:0]            core_isize,
  input  logic [31:0]            core_crc32,
  input  logic                   out_last_seen,
  input  logic                   abort,
  output logic                   sts_valid,
  input  logic                   sts_ready,
  output logic [2:0]             sts_code,
  output logic [31:0]            sts_isize,
  output logic [31:0]            sts_crc32,
  output logic                   busy,
  output logic                   irq
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_FEED   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam logic [7:0]             RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [WORDS_WIDTH-1:0] WORDS_ONE = WORDS_WIDTH'(1);

  logic [2:0]             r_state;
  logic                   r_gzipRstN;
  logic [1:0]             r_btype;
  logic                   r_revEndian;
  logic [WORDS_WIDTH-1:0] r_wordsLeft;
  logic [7:0]             r_rstCnt;
  logic                   r_doneFlag;
  logic                   r_lastFlag;
  logic [2:0]             r_stsCode;
  logic [31:0]            r_stsIsize;
  logic [31:0]            r_stsCrc;
  logic                   r_irq;

  logic w_xfer;
  logic w_doneSeen;
  logic w_lastSeen;
  logic w_complete;
  logic w_active;
  logic w_timeout;
  logic w_kill;

  assign w_xfer     = (r_state == S_FEED) & s_tvalid & ~core_full;
  assign w_doneSeen = r_doneFlag | ((r_state == S_DRAIN) & core_done);
  assign w_lastSeen = r_lastFlag | (((r_state == S_FEED) | (r_state == S_DRAIN)) & out_last_seen);
  assign w_complete = (r_state == S_DRAIN) & w_doneSeen & w_lastSeen;
  assign w_active   = (r_state == S_RESET) | (r_state == S_FEED) | (r_state == S_DRAIN);
  assign w_kill     = w_active & (abort | w_timeout);

`ifdef GZIP_SEQ_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;
  logic            w_wdogRun;
  logic            w_progress;

  // Held at zero outside FEED/DRAIN, so every entry into those states starts fresh.
  assign w_wdogRun  = (r_state == S_FEED) | (r_state == S_DRAIN);
  assign w_progress = w_xfer | (w_doneSeen & ~r_doneFlag) | (w_lastSeen & ~r_lastFlag);
  assign w_timeout  = w_wdogRun & (r_wdog == WD_LAST);

  always_ff @(posedge core_clock) begin
    if (bus_reset || !w_wdogRun || w_progress) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // Abort and watchdog override any per-state progress, including a same-cycle completion.
  always_ff @(posedge core_clock) begin
    if (bus_reset) begin
      r_state     <= S_IDLE;
      r_gzipRstN  <= 1'b0;
      r_btype     <= 2'b00;
      r_revEndian <= 1'b0;
      r_wordsLeft <= '0;
      r_rstCnt    <= '0;
      r_doneFlag  <= 1'b0;
      r_lastFlag  <= 1'b0;
      r_stsCode   <= 3'b000;
      r_stsIsize  <= '0;
      r_stsCrc    <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_kill) begin
        r_state    <= S_REPORT;
        r_gzipRstN <= 1'b0;
        r_stsCode  <= 3'b100;
        r_stsIsize <= '0;
        r_stsCrc   <= '0;
        r_irq      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (job_valid) begin
              if (job_words == '0) begin
                r_state    <= S_REPORT;
                r_stsCode  <= 3'b100;
                r_stsIsize <= '0;
                r_stsCrc   <= '0;
                r_irq      <= 1'b1;
              end else begin
                r_state     <= S_RESET;
                r_gzipRstN  <= 1'b0;
                r_btype     <= job_btype;
                r_revEndian <= job_rev_endian;
                r_wordsLeft <= job_words;
                r_rstCnt    <= '0;
                r_doneFlag  <= 1'b0;
                r_lastFlag  <= 1'b0;
              end
            end
          end
          S_RESET: begin
            if (r_rstCnt == RST_LAST) begin
              r_state    <= S_FEED;
              r_gzipRstN <= 1'b1;
            end else begin
              r_rstCnt <= r_rstCnt + 8'd1;
            end
          end
          S_FEED: begin
            r_lastFlag <= w_lastSeen;
            if (w_xfer) begin
              r_wordsLeft <= r_wordsLeft - WORDS_ONE;
              if (r_wordsLeft == WORDS_ONE) begin
                r_state <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            r_doneFlag <= w_doneSeen;
            r_lastFlag <= w_lastSeen;
            if (w_complete) begin
              r_state    <= S_REPORT;
              r_stsCode  <= {1'b0, core_btype_error, core_block_size_error};
              r_stsIsize <= core_isize;
              r_stsCrc   <= core_crc32;
              r_irq      <= 1'b1;
            end
          end
          S_REPORT: begin
            if (sts_ready) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign job_ready           = (r_state == S_IDLE);
  assign busy                = (r_state != S_IDLE);
  assign s_tready            = w_xfer;
  assign core_wr_en          = w_xfer;
  assign core_wr_data        = s_tdata;
  assign gzip_rst_n          = r_gzipRstN;
  assign gzip_btype          = r_btype;
  assign gzip_rev_endianness = r_revEndian;
  assign sts_valid           = (r_state == S_REPORT);
  assign sts_code            = r_stsCode;
  assign sts_isize           = r_stsIsize;
  assign sts_crc32           = r_stsCrc;
  assign irq                 = r_irq;

endmodule

// File: tb/tb_gzip_job_sequencer.sv
// Self-checking bench for gzip_job_sequencer: directed scenarios plus randomized jobs
// checked against a job-level model (words written, status record, reset pulse length).
`timescale 1ns/1ps
module tb_gzip_job_sequencer;

  localparam int RST_CYCLES  = 4;
  localparam int WORDS_WIDTH = 24;

  logic                   core_clock = 1'b0;
  logic                   bus_reset;
  logic                   job_valid;
  logic                   job_ready;
  logic [WORDS_WIDTH-1:0] job_words;
  logic [1:0]             job_btype;
  logic                   job_rev_endian;
  logic [31:0]            s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   core_wr_en;
  logic [31:0]            core_wr_data;
  logic                   core_full;
  logic                   gzip_rst_n;
  logic [1:0]             gzip_btype;
  logic                   gzip_rev_endianness;
  logic                   core_done;
  logic                   core_btype_error;
  logic                   core_block_size_error;
  logic [31:0]            core_isize;
  logic [31:0]            core_crc32;
  logic                   out_last_seen;
  logic                   abort;
  logic                   sts_valid;
  logic                   sts_ready;
  logic [2:0]             sts_code;
  logic [31:0]            sts_isize;
  logic [31:0]            sts_crc32;
  logic                   busy;
  logic                   irq;

  gzip_job_sequencer #(
    .RST_CYCLES(RST_CYCLES),
    .WORDS_WIDTH(WORDS_WIDTH),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .core_clock(core_clock), .bus_reset(bus_reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_words(job_words),
    .job_btype(job_btype), .job_rev_endian(job_rev_endian),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .core_wr_en(core_wr_en), .core_wr_data(core_wr_data), .core_full(core_full),
    .gzip_rst_n(gzip_rst_n), .gzip_btype(gzip_btype), .gzip_rev_endianness(gzip_rev_endianness),
    .core_done(core_done), .core_btype_error(core_btype_error),
    .core_block_size_error(core_block_size_error),
    .core_isize(core_isize), .core_crc32(core_crc32),
    .out_last_seen(out_last_seen), .abort(abort),
    .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_code(sts_code),
    .sts_isize(sts_isize), .sts_crc32(sts_crc32), .busy(busy), .irq(irq)
  );

  always #5 core_clock = ~core_clock;

  int checks = 0;
  int errors = 0;

  // Passive monitor, sampling mid-cycle after the drivers have settled.
  int          monWrites = 0;
  int          monFullWrites = 0;
  int          monRstLow = 0;
  int          monIrq = 0;
  logic [31:0] monData[$];

  always @(negedge core_clock) begin
    #2;
    if (core_wr_en === 1'b1) begin
      monWrites++;
      monData.push_back(core_wr_data);
      if (core_full !== 1'b0) monFullWrites++;
    end
    if (gzip_rst_n === 1'b0) monRstLow++;
    if (irq === 1'b1) monIrq++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit got=expired expected=finish");
    $fatal(1, "[TB] time limit");
  end

  // Observations of the most recent job.
  logic [31:0] stream[$];
  logic [31:0] obsData[$];
  int          obsWrites, obsFullWrites, obsRstLow, obsIrq, obsActive, obsLatency;
  logic        obsTimedOut, obsReady, obsIrqFirst, obsStable, obsIdle, obsRev;
  logic [2:0]  obsCode;
  logic [31:0] obsIsize, obsCrc;
  logic [1:0]  obsBtype;

  task automatic run_job(input int words, input logic [1:0] bt, input logic rev,
                         input int fullMode, input int validMode,
                         input int doneDelay, input int lastDelay,
                         input logic btErr, input logic bsErr,
                         input logic [31:0] isz, input logic [31:0] crc,
                         input int abortAt, input int holdCycles, input int budget);
    int  baseWrites, baseFull, baseRst, baseIrq, baseData;
    int  idx, feedEndCnt, doneCyc, lastCyc, stsCyc;
    bit  gotSts, fed;
    stream.delete();
    obsData.delete();
    for (int i = 0; i < words + 4; i++) stream.push_back($urandom);
    @(negedge core_clock);
    job_valid      = 1'b1;
    job_words      = WORDS_WIDTH'(words);
    job_btype      = bt;
    job_rev_endian = rev;
    #1 obsReady = job_ready;
    @(posedge core_clock);
    #1;
    job_valid             = 1'b0;
    core_btype_error      = btErr;
    core_block_size_error = bsErr;
    core_isize            = isz;
    core_crc32            = crc;
    baseWrites = monWrites; baseFull = monFullWrites; baseRst = monRstLow;
    baseIrq = monIrq; baseData = monData.size();
    idx = 0; feedEndCnt = 0; doneCyc = -1; lastCyc = -1; stsCyc = 0;
    gotSts = 0; obsActive = 0; obsTimedOut = 1'b0; obsBtype = 2'b00; obsRev = 1'b0;
    for (int cyc = 0; cyc < budget && !gotSts; cyc++) begin
      @(negedge core_clock);
      if (sts_valid === 1'b1) begin
        gotSts = 1;
        stsCyc = cyc;
      end else begin
        if (busy === 1'b1 && gzip_rst_n === 1'b1) begin
          obsActive++;
          obsBtype = gzip_btype;
          obsRev   = gzip_rev_endianness;
        end
        abort = (abortAt >= 0 && obsActive == abortAt);
        case (validMode)
          0:       s_tvalid = 1'b1;
          1:       s_tvalid = ($urandom_range(3) != 0);
          default: s_tvalid = 1'b0;
        endcase
        s_tdata = stream[idx];
        case (fullMode)
          0:       core_full = 1'b0;
          1:       core_full = cyc[0];
          default: core_full = ($urandom_range(3) == 0);
        endcase
        fed = ((monWrites - baseWrites) >= words);
        if (fed) feedEndCnt++;
        core_done     = fed && (feedEndCnt > doneDelay);
        out_last_seen = fed && (feedEndCnt == lastDelay + 1);
        if (core_done && doneCyc < 0) doneCyc = cyc;
        if (out_last_seen) lastCyc = cyc;
        #1;
        if (s_tready === 1'b1) idx++;
      end
    end
    s_tvalid = 1'b0; core_done = 1'b0; out_last_seen = 1'b0; abort = 1'b0; core_full = 1'b0;
    obsIdle = 1'b0; obsStable = 1'b0; obsIrqFirst = 1'b0;
    obsLatency = stsCyc - ((doneCyc > lastCyc) ? doneCyc : lastCyc);
    if (!gotSts) begin
      obsTimedOut = 1'b1;
    end else begin
      obsCode = sts_code; obsIsize = sts_isize; obsCrc = sts_crc32; obsIrqFirst = irq;
      obsStable = 1'b1;
      repeat (holdCycles) begin
        @(negedge core_clock);
        if (sts_valid !== 1'b1 || sts_code !== obsCode || sts_isize !== obsIsize ||
            sts_crc32 !== obsCrc) obsStable = 1'b0;
      end
      sts_ready = 1'b1;
      @(negedge core_clock);
      sts_ready = 1'b0;
      #1 obsIdle = (busy === 1'b0) && (sts_valid === 1'b0) && (job_ready === 1'b1);
    end
    obsWrites = monWrites - baseWrites; obsFullWrites = monFullWrites - baseFull;
    obsRstLow = monRstLow - baseRst;    obsIrq = monIrq - baseIrq;
    for (int i = baseData; i < monData.size(); i++) obsData.push_back(monData[i]);
  endtask

  task automatic test_reset();
    bus_reset = 1'b1;
    repeat (3) @(negedge core_clock);
    s_tvalid = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b expected=0", busy); end
    checks++; if (gzip_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_gzip_rst_n got=%b expected=0", gzip_rst_n); end
    checks++; if (gzip_btype !== 2'b00 || gzip_rev_endianness !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg got=%b/%b expected=00/0", gzip_btype, gzip_rev_endianness); end
    checks++; if (sts_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_sts_valid_irq got=%b/%b expected=0/0", sts_valid, irq); end
    checks++; if (sts_code !== 3'b000 || sts_isize !== 32'h0 || sts_crc32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_sts got=%b/%h/%h expected=0/0/0", sts_code, sts_isize, sts_crc32); end
    checks++; if (s_tready !== 1'b0 || core_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_stream got=%b/%b expected=0/0", s_tready, core_wr_en); end
    bus_reset = 1'b0;
    s_tvalid  = 1'b0;
    @(negedge core_clock);
    #1;
    checks++; if (job_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_job_ready got=%b expected=1", job_ready); end
  endtask

  task automatic test_basic();
    run_job(3, 2'b01, 1'b1, 0, 0, 10, 12, 1'b0, 1'b0, 32'd12, 32'hCBF43926, -1, 2, 500);
    checks++; if (obsTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout got=%b expected=0", obsTimedOut); end
    checks++; if (obsReady !== 1'b1) begin errors++; $display("[TB] FAIL basic_job_ready got=%b expected=1", obsReady); end
    checks++; if (obsRstLow !== RST_CYCLES) begin errors++; $display("[TB] FAIL basic_rst_low got=%0d expected=%0d", obsRstLow, RST_CYCLES); end
    checks++; if (obsWrites !== 3) begin errors++; $display("[TB] FAIL basic_writes got=%0d expected=3", obsWrites); end
    for (int i = 0; i < obsWrites && i < stream.size(); i++) begin
      checks++; if (obsData[i] !== stream[i]) begin errors++; $display("[TB] FAIL basic_data%0d got=%h expected=%h", i, obsData[i], stream[i]); end
    end
    checks++; if (obsBtype !== 2'b01 || obsRev !== 1'b1) begin errors++; $display("[TB] FAIL basic_cfg got=%b/%b expected=01/1", obsBtype, obsRev); end
    checks++; if (obsCode !== 3'b000) begin errors++; $display("[TB] FAIL basic_code got=%b expected=000", obsCode); end
    checks++; if (obsIsize !== 32'd12) begin errors++; $display("[TB] FAIL basic_isize got=%0d expected=12", obsIsize); end
    checks++; if (obsCrc !== 32'hCBF43926) begin errors++; $display("[TB] FAIL basic_crc got=%h expected=cbf43926", obsCrc); end
    checks++; if (obsLatency !== 1) begin errors++; $display("[TB] FAIL basic_latency got=%0d expected=1", obsLatency); end
    checks++; if (obsIrq !== 1 || obsIrqFirst !== 1'b1) begin errors++; $display("[TB] FAIL basic_irq got=%0d/%b expected=1/1", obsIrq, obsIrqFirst); end
    checks++; if (obsIdle !== 1'b1) begin errors++; $display("[TB] FAIL basic_idle got=%b expected=1", obsIdle); end
  endtask

  task automatic test_full_toggle();
    run_job(4, 2'b10, 1'b0, 1, 0, 2, 3, 1'b0, 1'b0, 32'd16, 32'h1234ABCD, -1, 0, 500);
    checks++; if (obsTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL full_timeout got=%b expected=0", obsTimedOut); end
    checks++; if (obsWrites !== 4) begin errors++; $display("[TB] FAIL full_writes got=%0d expected=4", obsWrites); end
    checks++; if (obsFullWrites !== 0) begin errors++; $display("[TB] FAIL full_write_while_full got=%0d expected=0", obsFullWrites); end
    for (int i = 0; i < obsWrites && i < stream.size(); i++) begin
      checks++; if (obsData[i] !== stream[i]) begin errors++; $display("[TB] FAIL full_data%0d got=%h expected=%h", i, obsData[i], stream[i]); end
    end
    checks++; if (obsCode !== 3'b000 || obsIsize !== 32'd16) begin errors++; $display("[TB] FAIL full_sts got=%b/%0d expected=000/16", obsCode, obsIsize); end
  endtask

  task automatic test_same_cycle_error();
    run_job(2, 2'b11, 1'b0, 0, 0, 3, 3, 1'b1, 1'b0, 32'd8, 32'h0BADF00D, -1, 0, 500);
    checks++; if (obsTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL same_timeout got=%b expected=0", obsTimedOut); end
    checks++; if (obsCode !== 3'b010) begin errors++; $display("[TB] FAIL same_code got=%b expected=010", obsCode); end
    checks++; if (obsLatency !== 1) begin errors++; $display("[TB] FAIL same_latency got=%0d expected=1", obsLatency); end
    checks++; if (obsCrc !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL same_crc got=%h expected=0badf00d", obsCrc); end
  endtask

  task automatic test_zero_length();
    run_job(0, 2'b01, 1'b0, 0, 0, 1000, 1000, 1'b1, 1'b1, 32'hFFFF0000, 32'hDEADBEEF, -1, 5, 50);
    checks++; if (obsTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL zero_timeout got=%b expected=0", obsTimedOut); end
    checks++; if (obsRstLow !== 0) begin errors++; $display("[TB] FAIL zero_rst_low got=%0d expected=0", obsRstLow); end
    checks++; if (obsWrites !== 0) begin errors++; $display("[TB] FAIL zero_writes got=%0d expected=0", obsWrites); end
    checks++; if (obsCode !== 3'b100) begin errors++; $display("[TB] FAIL zero_code got=%b expected=100", obsCode); end
    checks++; if (obsIsize !== 32'h0 || obsCrc !== 32'h0) begin errors++; $display("[TB] FAIL zero_isize_crc got=%h/%h expected=0/0", obsIsize, obsCrc); end
    checks++; if (obsIrq !== 1) begin errors++; $display("[TB] FAIL zero_irq got=%0d expected=1", obsIrq); end
    checks++; if (obsStable !== 1'b1) begin errors++; $display("[TB] FAIL zero_stable got=%b expected=1", obsStable); end
  endtask

  task automatic test_midjob_reset();
    @(negedge core_clock);
    job_valid = 1'b1; job_words = WORDS_WIDTH'(6); job_btype = 2'b11; job_rev_endian = 1'b1;
    @(negedge core_clock);
    job_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hA5A5_0001; core_full = 1'b0;
    repeat (RST_CYCLES + 2) @(negedge core_clock);
    #1;
    checks++; if (busy !== 1'b1 || s_tready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_feed got=%b/%b expected=1/1", busy, s_tready); end
    bus_reset = 1'b1;
    @(negedge core_clock);
    #1;
    checks++; if (busy !== 1'b0 || sts_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_state got=%b/%b expected=0/0", busy, sts_valid); end
    checks++; if (gzip_rst_n !== 1'b0 || gzip_btype !== 2'b00 || s_tready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_outputs got=%b/%b/%b expected=0/00/0", gzip_rst_n, gzip_btype, s_tready); end
    bus_reset = 1'b0; s_tvalid = 1'b0;
    @(negedge core_clock);
    #1;
    checks++; if (job_ready !== 1'b1 || sts_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_after got=%b/%b expected=1/0", job_ready, sts_valid); end
  endtask

  task automatic test_abort();
    run_job(8, 2'b01, 1'b0, 0, 0, 1000, 1000, 1'b0, 1'b0, 32'h55, 32'h66, 2, 1, 500);
    checks++; if (obsTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL abort_timeout got=%b expected=0", obsTimedOut); end
    checks++; if (obsCode !== 3'b100) begin errors++; $display("[TB] FAIL abort_code got=%b expected=100", obsCode); end
    checks++; if (obsIsize !== 32'h0 || obsCrc !== 32'h0) begin errors++; $display("[TB] FAIL abort_isize_crc got=%h/%h expected=0/0", obsIsize, obsCrc); end
    checks++; if (obsWrites !== 2) begin errors++; $display("[TB] FAIL abort_writes got=%0d expected=2", obsWrites); end
    checks++; if (obsIrq !== 1) begin errors++; $display("[TB] FAIL abort_irq got=%0d expected=1", obsIrq); end
    repeat (3) @(negedge core_clock);
    #1;
    checks++; if (gzip_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL abort_rst_held got=%b expected=0", gzip_rst_n); end
    run_job(1, 2'b00, 1'b1, 0, 0, 1, 2, 1'b0, 1'b0, 32'd4, 32'h11223344, -1, 0, 500);
    checks++; if (obsTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL abort_next_timeout got=%b expected=0", obsTimedOut); end
    checks++; if (obsCode !== 3'b000 || obsIsize !== 32'd4 || obsCrc !== 32'h11223344) begin errors++; $display("[TB] FAIL abort_next_sts got=%b/%0d/%h expected=000/4/11223344", obsCode, obsIsize, obsCrc); end
    checks++; if (obsWrites !== 1 || obsRstLow !== RST_CYCLES) begin errors++; $display("[TB] FAIL abort_next_feed got=%0d/%0d expected=1/%0d", obsWrites, obsRstLow, RST_CYCLES); end
  endtask

  // Job-level reference model: a job of N>0 words writes exactly the first N offered
  // words, pulses the core reset RST_CYCLES cycles and reports the core's results.
  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      int          words, dd, ld, hold;
      logic [1:0]  bt;
      logic        rev, be, se;
      logic [31:0] isz, crc;
      logic [2:0]  expCode;
      words = ($urandom_range(5) == 0) ? 0 : int'($urandom_range(7, 1));
      bt = 2'($urandom_range(3)); rev = 1'($urandom_range(1));
      be = 1'($urandom_range(1)); se = 1'($urandom_range(1));
      dd = int'($urandom_range(10)); ld = int'($urandom_range(10)); hold = int'($urandom_range(3));
      isz = $urandom; crc = $urandom;
      run_job(words, bt, rev, 2 * int'($urandom_range(1)), int'($urandom_range(1)),
              dd, ld, be, se, isz, crc, -1, hold, 1000);
      expCode = (words == 0) ? 3'b100 : {1'b0, be, se};
      checks++; if (obsTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_timeout got=%b expected=0", j, obsTimedOut); end
      checks++; if (obsCode !== expCode) begin errors++; $display("[TB] FAIL rand%0d_code got=%b expected=%b", j, obsCode, expCode); end
      checks++; if (obsIsize !== ((words == 0) ? 32'h0 : isz) || obsCrc !== ((words == 0) ? 32'h0 : crc)) begin errors++; $display("[TB] FAIL rand%0d_isize_crc got=%h/%h expected=%h/%h", j, obsIsize, obsCrc, (words == 0) ? 32'h0 : isz, (words == 0) ? 32'h0 : crc); end
      checks++; if (obsWrites !== words || obsFullWrites !== 0) begin errors++; $display("[TB] FAIL rand%0d_writes got=%0d/%0d expected=%0d/0", j, obsWrites, obsFullWrites, words); end
      for (int i = 0; i < obsWrites && i < stream.size(); i++) begin
        checks++; if (obsData[i] !== stream[i]) begin errors++; $display("[TB] FAIL rand%0d_data%0d got=%h expected=%h", j, i, obsData[i], stream[i]); end
      end
      checks++; if (obsRstLow !== ((words == 0) ? 0 : RST_CYCLES)) begin errors++; $display("[TB] FAIL rand%0d_rst_low got=%0d expected=%0d", j, obsRstLow, (words == 0) ? 0 : RST_CYCLES); end
      checks++; if (obsIrq !== 1 || obsIrqFirst !== 1'b1 || obsStable !== 1'b1 || obsIdle !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_report got=%0d/%b/%b/%b expected=1/1/1/1", j, obsIrq, obsIrqFirst, obsStable, obsIdle); end
      if (words != 0) begin
        checks++; if (obsBtype !== bt || obsRev !== rev) begin errors++; $display("[TB] FAIL rand%0d_cfg got=%b/%b expected=%b/%b", j, obsBtype, obsRev, bt, rev); end
        checks++; if (obsLatency !== 1) begin errors++; $display("[TB] FAIL rand%0d_latency got=%0d expected=1", j, obsLatency); end
      end
    end
  endtask

`ifdef GZIP_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_job(2, 2'b01, 1'b0, 0, 2, 1000, 1000, 1'b0, 1'b0, 32'h77, 32'h88, -1, 0, 200);
    checks++; if (obsTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL timeout_report got=%b expected=0", obsTimedOut); end
    checks++; if (obsActive !== 16) begin errors++; $display("[TB] FAIL timeout_cycles got=%0d expected=16", obsActive); end
    checks++; if (obsCode !== 3'b100 || obsIsize !== 32'h0) begin errors++; $display("[TB] FAIL timeout_sts got=%b/%h expected=100/0", obsCode, obsIsize); end
    #1;
    checks++; if (gzip_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL timeout_rst got=%b expected=0", gzip_rst_n); end
  endtask
`else
  task automatic test_no_timeout();
    run_job(2, 2'b01, 1'b0, 0, 2, 1000, 1000, 1'b0, 1'b0, 32'h77, 32'h88, -1, 0, 100);
    checks++; if (obsTimedOut !== 1'b1) begin errors++; $display("[TB] FAIL no_timeout_report got=%b expected=1", obsTimedOut); end
    #1;
    checks++; if (busy !== 1'b1 || sts_valid !== 1'b0 || gzip_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL no_timeout_in_feed got=%b/%b/%b expected=1/0/1", busy, sts_valid, gzip_rst_n); end
    @(negedge core_clock);
    abort = 1'b1;
    @(negedge core_clock);
    abort = 1'b0;
    #1;
    checks++; if (sts_valid !== 1'b1 || sts_code !== 3'b100) begin errors++; $display("[TB] FAIL no_timeout_abort got=%b/%b expected=1/100", sts_valid, sts_code); end
    sts_ready = 1'b1;
    @(negedge core_clock);
    sts_ready = 1'b0;
  endtask
`endif

  initial begin
    bus_reset = 1'b1; job_valid = 1'b0; job_words = '0; job_btype = 2'b00; job_rev_endian = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; core_full = 1'b0; core_done = 1'b0;
    core_btype_error = 1'b0; core_block_size_error = 1'b0; core_isize = '0; core_crc32 = '0;
    out_last_seen = 1'b0; abort = 1'b0; sts_ready = 1'b0;
    test_reset();
    test_basic();
    test_full_toggle();
    test_same_cycle_error();
    test_zero_length();
    test_midjob_reset();
    test_abort();
    test_random();
`ifdef GZIP_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gzip_job_sequencer.md
Name: gzip_job_sequencer

Overview:
- Single-clock controller between the register/stream front end and the Deflate core.
- Accepts one compression job descriptor at a time (word count, btype, endianness).
- Sequences the job: core reset pulse, configuration, gated input feed of exactly the job length, then wait for core completion and the final output word.
- Returns one status record per job (error code, ISIZE, CRC32) and raises an interrupt pulse.

Parameters:
- RST_CYCLES, 4, cycles gzip_rst_n is held low at job start (legal range 1..255).
- WORDS_WIDTH, 24, width of the job word counter.
- TIMEOUT_CYCLES, 1048576, watchdog limit in cycles without progress (used only with GZIP_SEQ_TIMEOUT_EN).

Ports:
- core_clock  in  1  sole clock.
- bus_reset  in  1  synchronous, active-high reset.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  descriptor accepted when job_valid & job_ready.
- job_words  in  WORDS_WIDTH  number of 32-bit input words in the job.
- job_btype  in  2  compression mode for the job.
- job_rev_endian  in  1  endianness swap for the job.
- s_tdata  in  32  upstream input word.
- s_tvalid  in  1  upstream word valid.
- s_tready  out  1  upstream word taken.
- core_wr_en  out  1  write strobe to the core input FIFO.
- core_wr_data  out  32  data to the core input FIFO.
- core_full  in  1  core input FIFO full.
- gzip_rst_n  out  1  core reset, active-low.
- gzip_btype  out  2  latched btype driven to the core.
- gzip_rev_endianness  out  1  latched endianness driven to the core.
- core_done  in  1  core done flag (level).
- core_btype_error  in  1  core btype error flag.
- core_block_size_error  in  1  core block size error flag.
- core_isize  in  32  core ISIZE.
- core_crc32  in  32  core CRC32.
- out_last_seen  in  1  one-cycle pulse when the output word carrying tlast is accepted downstream.
- abort  in  1  software abort request.
- sts_valid  out  1  status record valid.
- sts_ready  in  1  status record consumed.
- sts_code  out  3  status: bit0 block_size_error, bit1 btype_error, bit2 timeout/abort/zero-length.
- sts_isize  out  32  captured ISIZE.
- sts_crc32  out  32  captured CRC32.
- busy  out  1  high in any state other than IDLE.
- irq  out  1  one-cycle pulse on entry to REPORT.

Behaviour:
- Reset values (bus_reset=1 at an edge): state IDLE, gzip_rst_n=0, gzip_btype=0, gzip_rev_endianness=0, sts_valid=0, sts_code=0, sts_isize=0, sts_crc32=0, irq=0, busy=0, counters 0. job_ready goes high in the first cycle after reset deasserts.
- States: IDLE, RESET, FEED, DRAIN, REPORT.
- IDLE:
  - job_ready=1; gzip_rst_n keeps its last value.
  - On accept with job_words!=0: latch btype, endianness and word count, clear the sticky flags, go to RESET.
  - On accept with job_words==0: go to REPORT directly with sts_code=3'b100 and isize/crc=0; the core is not touched.
- RESET:
  - gzip_rst_n=0 for exactly RST_CYCLES cycles, then FEED.
  - Timing: job accepted at edge T gives gzip_rst_n low for cycles T+1..T+RST_CYCLES; FEED is entered at T+RST_CYCLES+1 with gzip_rst_n=1.
- FEED:
  - core_wr_en = s_tready = s_tvalid & ~core_full (combinational); core_wr_data = s_tdata.
  - The remaining-word count decrements on each transfer.
  - The transfer taking the count 1→0 moves to DRAIN; no further upstream words are taken.
- DRAIN:
  - s_tready=0, core_wr_en=0.
  - Sticky flags set on core_done and on out_last_seen, in either order or in the same cycle. out_last_seen is also captured if it arrives during FEED.
  - When both flags are set, capture core_isize, core_crc32 and the error bits into the sts_* registers and go to REPORT.
- REPORT:
  - sts_valid=1 and sts_* stay stable until sts_ready; then IDLE next cycle.
  - irq=1 only in the first REPORT cycle.
  - gzip_rst_n stays 1 after a normal job; the core holds its results.
- abort in RESET/FEED/DRAIN:
  - Next state REPORT with sts_code=3'b100 and isize/crc=0.
  - gzip_rst_n driven 0 from the next cycle and held 0 until the next job's FEED.
  - abort in IDLE or REPORT is ignored.
- Simultaneous abort and completion in DRAIN: abort wins.
- bus_reset mid-job: immediate return to IDLE with all reset values; any pending status is discarded.
- busy = (state != IDLE).

Optional Feature:
- Macro GZIP_SEQ_TIMEOUT_EN, defined:
  - A watchdog counter runs in FEED/DRAIN. It clears on state entry, on every core_wr_en, and on every 0→1 change of the done or last flags.
  - When it reaches TIMEOUT_CYCLES-1, the block behaves exactly as abort: REPORT, sts_code bit2=1, gzip_rst_n=0.
- Macro not defined: no counter is built, TIMEOUT_CYCLES is unused, and only abort or a zero-length job set bit2.

Test Plan:
- Job words=3, btype=01, RST_CYCLES=4. Stream 5 valid words, core_full=0. Then core_done at cycle +10 and out_last_seen at +12 with isize=12, crc=32'hCBF43926.
  - gzip_rst_n low for exactly 4 cycles; exactly 3 writes; s_tready=0 afterwards.
  - sts_code=0, sts_isize=12, sts_crc32=32'hCBF43926; one irq pulse.
- core_full toggling every other cycle during FEED of a 4-word job → 4 writes, none while core_full=1; DRAIN entered right after the 4th write.
- core_done and out_last_seen in the same cycle with core_btype_error=1 → REPORT next cycle with sts_code=3'b010.
- Zero-length job → no gzip_rst_n activity; sts_code=3'b100; isize=0; irq pulse. With sts_ready held low for 5 cycles, sts_* stay stable.
- abort in the 2nd FEED cycle of an 8-word job → sts_code=3'b100; gzip_rst_n=0 until the next job. A following 1-word job completes normally with sts_code=0.
- With GZIP_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, s_tvalid=0 in FEED → REPORT after 16 idle cycles with sts_code=3'b100; without the macro, the block is still in FEED at cycle 100.
